// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Included by the stage, its MEM/WB register and its SRAM interface.
package mem_stage_pkg;

    localparam int unsigned DATA_W        = 32;
    localparam int unsigned REG_ADDR_W    = 4;
    localparam int unsigned MEM_ADDR_BASE = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

endpackage

// File: rtl/memory_access_stage_if.sv
// Word-SRAM request/acknowledge bus between the MEM stage (master) and memory (slave).
interface memory_access_stage_if #(
    parameter int unsigned SRAM_ADDR_W = 16
);

    logic                            sram_req;
    logic                            sram_we;
    logic [SRAM_ADDR_W-1:0]          sram_addr;
    logic [mem_stage_pkg::DATA_W-1:0] sram_wdata;
    logic [mem_stage_pkg::DATA_W-1:0] sram_rdata;
    logic                            sram_ack;

    modport master (
        output sram_req, sram_we, sram_addr, sram_wdata,
        input  sram_rdata, sram_ack
    );

    modport slave (
        input  sram_req, sram_we, sram_addr, sram_wdata,
        output sram_rdata, sram_ack
    );

endinterface

// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: captures its inputs whenever en_i is high, holds otherwise.
module mem_wb_register
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic [DATA_W-1:0]     alu_i,
    input  logic                  mre_i,
    input  logic                  wbe_i,
    input  logic [REG_ADDR_W-1:0] dest_i,
    output logic [DATA_W-1:0]     data_o,
    output logic [DATA_W-1:0]     alu_o,
    output logic                  mre_o,
    output logic                  wbe_o,
    output logic [REG_ADDR_W-1:0] dest_o
);

    logic [DATA_W-1:0]     data_q;
    logic [DATA_W-1:0]     alu_q;
    logic                  mre_q;
    logic                  wbe_q;
    logic [REG_ADDR_W-1:0] dest_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            alu_q  <= '0;
            mre_q  <= 1'b0;
            wbe_q  <= 1'b0;
            dest_q <= '0;
        end else if (en_i) begin
            data_q <= data_i;
            alu_q  <= alu_i;
            mre_q  <= mre_i;
            wbe_q  <= wbe_i;
            dest_q <= dest_i;
        end
    end

    assign data_o = data_q;
    assign alu_o  = alu_q;
    assign mre_o  = mre_q;
    assign wbe_o  = wbe_q;
    assign dest_o = dest_q;

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack SRAM bus and freezes upstream meanwhile.
// Define MEM_TIMEOUT_EN to abort accesses that see no ack within TIMEOUT cycles (sets mem_error).
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = MEM_ADDR_BASE,
    parameter int unsigned SRAM_ADDR_W = 16,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      aluResultIn,
    input  logic [DATA_W-1:0]      storeValue,
    input  logic                   memReadIn,
    input  logic                   memWriteIn,
    input  logic                   wbEnableIn,
    input  logic [REG_ADDR_W-1:0]  destRegIn,
    output logic                   freeze,
    output logic [DATA_W-1:0]      data,
    output logic [DATA_W-1:0]      aluResult,
    output logic                   memoryReadEnabled,
    output logic                   wbEnable,
    output logic [REG_ADDR_W-1:0]  destReg,
    memory_access_stage_if.master  sram,
    output logic                   mem_error
);

    if (TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must fit the 8-bit access counter");
    end

    mem_state_e             state_q, state_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   mem_op;
    logic                   expired;
    logic [DATA_W-1:0]      wb_data;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Abort on the TIMEOUT-th ACCESS cycle, counting the current one.
    assign expired   = (cnt_q + 8'd1) == 8'(TIMEOUT);
    assign mem_error = err_q;
`else
    assign expired   = 1'b0;
    assign mem_error = 1'b0;
`endif

    assign mem_op  = memReadIn | memWriteIn;
    assign freeze  = (state_q == ACCESS) || ((state_q == IDLE) && mem_op);
    assign wb_data = (state_q == DONE) ? rdata_q : '0;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d = ACCESS;
                    req_d   = 1'b1;
                    we_d    = memWriteIn;
                    // Below-base addresses wrap modulo 2^32 before truncation.
                    addr_d  = SRAM_ADDR_W'((aluResultIn - DATA_W'(ADDR_BASE)) >> 2);
                    wdata_d = storeValue;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ACCESS: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (sram.sram_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = we_q ? '0 : sram.sram_rdata;
                end else if (expired) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = '0;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign sram.sram_req   = req_q;
    assign sram.sram_we    = we_q;
    assign sram.sram_addr  = addr_q;
    assign sram.sram_wdata = wdata_q;

    mem_wb_register u_mem_wb (
        .clk    (clk),
        .rst    (rst),
        .en_i   (~freeze),
        .data_i (wb_data),
        .alu_i  (aluResultIn),
        .mre_i  (memReadIn),
        .wbe_i  (wbEnableIn),
        .dest_i (destRegIn),
        .data_o (data),
        .alu_o  (aluResult),
        .mre_o  (memoryReadEnabled),
        .wbe_o  (wbEnable),
        .dest_o (destReg)
    );

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage with a scoreboard of expected MEM/WB contents.
`timescale 1ns/1ps
module tb_memory_access_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] aluResultIn = '0;
    logic [31:0] storeValue  = '0;
    logic        memReadIn   = 1'b0;
    logic        memWriteIn  = 1'b0;
    logic        wbEnableIn  = 1'b0;
    logic [3:0]  destRegIn   = '0;
    logic        freeze;
    logic [31:0] data;
    logic [31:0] aluResult;
    logic        memoryReadEnabled;
    logic        wbEnable;
    logic [3:0]  destReg;
    logic        mem_error;

    always #5 clk = ~clk;

    memory_access_stage_if #(.SRAM_ADDR_W(16)) bus ();

    memory_access_stage #(
        .ADDR_BASE   (1024),
        .SRAM_ADDR_W (16),
        .TIMEOUT     (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .aluResultIn       (aluResultIn),
        .storeValue        (storeValue),
        .memReadIn         (memReadIn),
        .memWriteIn        (memWriteIn),
        .wbEnableIn        (wbEnableIn),
        .destRegIn         (destRegIn),
        .freeze            (freeze),
        .data              (data),
        .aluResult         (aluResult),
        .memoryReadEnabled (memoryReadEnabled),
        .wbEnable          (wbEnable),
        .destReg           (destReg),
        .sram              (bus),
        .mem_error         (mem_error)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] alu;
        logic        mre;
        logic        wbe;
        logic [3:0]  dest;
    } wb_t;

    wb_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // Drives one instruction, plays the SRAM (ack on ACCESS cycle ack_wait, -1 = never),
    // and compares the MEM/WB register against the scoreboard once it captures.
    task automatic run_op(input string name, input logic [31:0] alu, input logic [31:0] sv,
                          input logic rd, input logic wr, input logic wbe, input logic [3:0] dst,
                          input int ack_wait, input logic [31:0] rdat,
                          output int frz, output int acc, output int unstable,
                          output logic [15:0] a_seen, output logic we_seen, output logic [31:0] wd_seen);
        wb_t  e, got;
        logic done;
        @(negedge clk);
        aluResultIn = alu; storeValue = sv; memReadIn = rd; memWriteIn = wr;
        wbEnableIn = wbe; destRegIn = dst;
        e.data = (rd && !wr && ack_wait >= 0) ? rdat : 32'd0;
        e.alu = alu; e.mre = rd; e.wbe = wbe; e.dest = dst;
        exp_q.push_back(e);
        frz = 0; acc = 0; unstable = 0; a_seen = '0; we_seen = 1'b0; wd_seen = '0; done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            if (cyc != 0) @(negedge clk);
            bus.sram_ack = 1'b0;
            #1;
            if (!freeze) begin
                done = 1'b1;
            end else begin
                frz++;
                if (bus.sram_req) begin
                    if (acc == 0) begin
                        a_seen = bus.sram_addr; we_seen = bus.sram_we; wd_seen = bus.sram_wdata;
                    end else if (bus.sram_addr !== a_seen || bus.sram_we !== we_seen ||
                                 bus.sram_wdata !== wd_seen) begin
                        unstable++;
                    end
                    if (acc == ack_wait) begin
                        bus.sram_ack = 1'b1; bus.sram_rdata = rdat;
                    end
                    acc++;
                end
            end
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s.freeze_release got=stuck required=release within 600 cycles", name);
        end
        if (done) begin
            @(posedge clk);
            #1;
        end
        got = '{data, aluResult, memoryReadEnabled, wbEnable, destReg};
        memReadIn = 1'b0; memWriteIn = 1'b0; wbEnableIn = 1'b0;
        e = exp_q.pop_front();
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s.memwb got=%h required=%h", name, got, e);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++; if (freeze !== 1'b0) begin fails++; $display("FAIL reset.freeze got=%b required=0", freeze); end
        tests++; if ({data, aluResult, memoryReadEnabled, wbEnable, destReg} !== '0) begin
            fails++; $display("FAIL reset.memwb got=%h/%h/%b/%b/%h required=0", data, aluResult, memoryReadEnabled, wbEnable, destReg); end
        tests++; if ({bus.sram_req, bus.sram_we, bus.sram_addr, bus.sram_wdata} !== '0) begin
            fails++; $display("FAIL reset.sram got=%b/%b/%h/%h required=0", bus.sram_req, bus.sram_we, bus.sram_addr, bus.sram_wdata); end
        tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL reset.mem_error got=%b required=0", mem_error); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_non_mem();
        int frz, acc, un; logic [15:0] a; logic we; logic [31:0] wd;
        run_op("nonmem", 32'h55, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3, 0, 32'h0, frz, acc, un, a, we, wd);
        tests++; if (frz !== 0) begin fails++; $display("FAIL nonmem.freeze_cycles got=%0d required=0", frz); end
        tests++; if (acc !== 0) begin fails++; $display("FAIL nonmem.req_cycles got=%0d required=0", acc); end
    endtask

    task automatic test_load();
        int frz, acc, un; logic [15:0] a; logic we; logic [31:0] wd;
        run_op("load", 32'd1032, 32'h0, 1'b1, 1'b0, 1'b1, 4'd5, 2, 32'hDEADBEEF, frz, acc, un, a, we, wd);
        tests++; if (a !== 16'd2) begin fails++; $display("FAIL load.addr got=%h required=0002", a); end
        tests++; if (we !== 1'b0) begin fails++; $display("FAIL load.we got=%b required=0", we); end
        tests++; if (frz !== 4) begin fails++; $display("FAIL load.freeze_cycles got=%0d required=4", frz); end
        tests++; if (un !== 0) begin fails++; $display("FAIL load.req_stable got=%0d changes required=0", un); end
    endtask

    task automatic test_store();
        int frz, acc, un; logic [15:0] a; logic we; logic [31:0] wd;
        run_op("store", 32'd1024, 32'h12345678, 1'b0, 1'b1, 1'b0, 4'd0, 0, 32'hFFFF0000, frz, acc, un, a, we, wd);
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL store.we got=%b required=1", we); end
        tests++; if (a !== 16'd0) begin fails++; $display("FAIL store.addr got=%h required=0000", a); end
        tests++; if (wd !== 32'h12345678) begin fails++; $display("FAIL store.wdata got=%h required=12345678", wd); end
        tests++; if (frz !== 2) begin fails++; $display("FAIL store.freeze_cycles got=%0d required=2", frz); end
        tests++; if (bus.sram_req !== 1'b0) begin fails++; $display("FAIL store.req_after got=%b required=0", bus.sram_req); end
    endtask

    task automatic test_both_and_wrap();
        int frz, acc, un; logic [15:0] a; logic we; logic [31:0] wd;
        run_op("both", 32'd1028, 32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 4'd9, 1, 32'h87654321, frz, acc, un, a, we, wd);
        tests++; if (we !== 1'b1) begin fails++; $display("FAIL both.we got=%b required=1", we); end
        tests++; if (frz !== 3) begin fails++; $display("FAIL both.freeze_cycles got=%0d required=3", frz); end
        run_op("wrap", 32'd0, 32'h0, 1'b1, 1'b0, 1'b1, 4'd1, 0, 32'h00000BAD, frz, acc, un, a, we, wd);
        tests++; if (a !== 16'hFF00) begin fails++; $display("FAIL wrap.addr got=%h required=ff00", a); end
    endtask

    task automatic test_spurious_ack();
        @(negedge clk);
        bus.sram_ack = 1'b1; bus.sram_rdata = 32'hBADBAD00;
        @(negedge clk);
        bus.sram_ack = 1'b0;
        #1;
        tests++; if (freeze !== 1'b0 || bus.sram_req !== 1'b0) begin
            fails++; $display("FAIL spurious.state got=freeze %b req %b required=0 0", freeze, bus.sram_req); end
    endtask

    task automatic test_back_to_back();
        int frz, acc, un; logic [15:0] a; logic we; logic [31:0] wd;
        run_op("b2b.load", 32'd1100, 32'h0, 1'b1, 1'b0, 1'b1, 4'd2, 0, 32'h0BADF00D, frz, acc, un, a, we, wd);
        run_op("b2b.alu", 32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 4'd4, 0, 32'h0, frz, acc, un, a, we, wd);
        run_op("b2b.store", 32'd2048, 32'hFACE0001, 1'b0, 1'b1, 1'b0, 4'd0, 3, 32'h0, frz, acc, un, a, we, wd);
        tests++; if (a !== 16'd256) begin fails++; $display("FAIL b2b.store_addr got=%h required=0100", a); end
        tests++; if (frz !== 5) begin fails++; $display("FAIL b2b.store_freeze got=%0d required=5", frz); end
    endtask

    task automatic test_reset_mid_access();
        int req_seen;
        @(negedge clk);
        aluResultIn = 32'd1040; storeValue = 32'hA5A5A5A5; memReadIn = 1'b1; wbEnableIn = 1'b1; destRegIn = 4'd7;
        @(negedge clk);
        #1;
        tests++; if (bus.sram_req !== 1'b1) begin fails++; $display("FAIL rstmid.req_before got=%b required=1", bus.sram_req); end
        memReadIn = 1'b0; wbEnableIn = 1'b0; aluResultIn = '0; storeValue = '0; destRegIn = '0;
        rst = 1'b0;
        #1;
        tests++; if ({bus.sram_req, bus.sram_we, bus.sram_addr, bus.sram_wdata} !== '0) begin
            fails++; $display("FAIL rstmid.sram got=%b/%b/%h/%h required=0", bus.sram_req, bus.sram_we, bus.sram_addr, bus.sram_wdata); end
        tests++; if ({data, aluResult, memoryReadEnabled, wbEnable, destReg, freeze} !== '0) begin
            fails++; $display("FAIL rstmid.memwb got=%h/%h/%b/%b/%h/%b required=0", data, aluResult, memoryReadEnabled, wbEnable, destReg, freeze); end
        @(negedge clk);
        rst = 1'b1;
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (bus.sram_req || freeze) req_seen++;
        end
        tests++; if (req_seen !== 0) begin fails++; $display("FAIL rstmid.no_retry got=%0d busy cycles required=0", req_seen); end
    endtask

    task automatic test_timeout();
        int frz, acc, un; logic [15:0] a; logic we; logic [31:0] wd;
`ifdef MEM_TIMEOUT_EN
        run_op("timeout", 32'd1064, 32'h0, 1'b1, 1'b0, 1'b1, 4'd6, -1, 32'h0, frz, acc, un, a, we, wd);
        tests++; if (acc !== 4) begin fails++; $display("FAIL timeout.access_cycles got=%0d required=4", acc); end
        tests++; if (frz !== 5) begin fails++; $display("FAIL timeout.freeze_cycles got=%0d required=5", frz); end
        tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL timeout.mem_error got=%b required=1", mem_error); end
        run_op("timeout.resume", 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 4'd8, 0, 32'h0, frz, acc, un, a, we, wd);
        tests++; if (mem_error !== 1'b1) begin fails++; $display("FAIL timeout.sticky got=%b required=1", mem_error); end
`else
        run_op("slow_ack", 32'd1064, 32'h0, 1'b1, 1'b0, 1'b1, 4'd6, 9, 32'h5A5A5A5A, frz, acc, un, a, we, wd);
        tests++; if (acc !== 10) begin fails++; $display("FAIL slow_ack.access_cycles got=%0d required=10", acc); end
        tests++; if (mem_error !== 1'b0) begin fails++; $display("FAIL slow_ack.mem_error got=%b required=0", mem_error); end
`endif
    endtask

    initial begin
        bus.sram_ack   = 1'b0;
        bus.sram_rdata = '0;
        test_reset();
        test_non_mem();
        test_load();
        test_store();
        test_both_and_wrap();
        test_spurious_ack();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=still running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
